mr_csr_unit: RTL and testbench

Parametrised machine-mode CSR unit and performance-counter block for the mr core, sitting between the decode/execute CSR path and the core's retirement and event signals. Its accepted CSR accesses are writable, with a mask. It supports RV32 or RV64, a configurable hart ID and number of hardware performance counters, mcountinhibit and mscratch, and a single-entry output buffer with backpressure so the consumer can stall.

---
 rtl/mr_csr_pkg.sv | 41 ++++
 rtl/mr_csr_counter.sv | 33 +++
 rtl/mr_csr_unit.sv | 162 ++++++++++++++++
 tb/tb_mr_csr_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mr_csr_pkg.sv
// rtl/mr_csr_pkg.sv - CSR addresses and helpers shared by the mr CSR unit
package mr_csr_pkg;

   localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
   localparam logic [11:0] CSR_MARCHID       = 12'hF12;
   localparam logic [11:0] CSR_MIMPID        = 12'hF13;
   localparam logic [11:0] CSR_MHARTID       = 12'hF14;
   localparam logic [11:0] CSR_MISA          = 12'h301;
   localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
   localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
   localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
   localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
   localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
   localparam logic [11:0] CSR_CYCLE         = 12'hC00;
   localparam logic [11:0] CSR_INSTRET       = 12'hC02;
   localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
   localparam logic [11:0] CSR_INSTRETH      = 12'hC82;

   localparam int CNT_CY = 0;
   localparam int CNT_IR = 2;

   // mcountinhibit bits backed by storage: CY, IR and the implemented HPMs
   function automatic logic [31:0] inhibit_mask(input int num_hpm);
      logic [31:0] m;
      m = '0;
      m[CNT_CY] = 1'b1;
      m[CNT_IR] = 1'b1;
      for (int k = 0; k < num_hpm; k++) m[3+k] = 1'b1;
      return m;
   endfunction

   // Low-half address of counter slot i: 0 mcycle, 1 minstret, 2.. mhpmcounter3..
   function automatic logic [11:0] ctr_addr(input int i);
      if (i == 0) return CSR_MCYCLE;
      if (i == 1) return CSR_MINSTRET;
      return CSR_MHPMCOUNTER3 + 12'(i - 2);
   endfunction

endpackage

// File: rtl/mr_csr_counter.sv
// rtl/mr_csr_counter.sv - 64-bit event counter with half-word write ports
module mr_csr_counter (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  inc_i,
   input  logic        inhibit_i,
   input  logic        wr_lo_i,
   input  logic        wr_hi_i,
   input  logic [63:0] wdata_i,
   output logic [63:0] cnt_o
);

   logic [63:0] cnt_q, cnt_d;

   // A write in the same cycle suppresses the increment; the unwritten half holds
   always_comb begin
      cnt_d = cnt_q;
      if (wr_lo_i || wr_hi_i) begin
         if (wr_lo_i) cnt_d[31:0]  = wdata_i[31:0];
         if (wr_hi_i) cnt_d[63:32] = wdata_i[63:32];
      end else if (!inhibit_i) begin
         cnt_d = cnt_q + {61'd0, inc_i};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/mr_csr_unit.sv
// rtl/mr_csr_unit.sv - machine-mode CSR unit with performance counters
module mr_csr_unit import mr_csr_pkg::*; #(
   parameter int          XLEN     = 32,
   parameter int unsigned HART_ID  = 0,
   parameter logic [63:0] MISA_VAL = 64'd0,
   parameter int          NUM_HPM  = 4
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [2:0]                             insts_ret,
   input  logic [(NUM_HPM > 0 ? NUM_HPM : 1)-1:0] hpm_event,
   input  logic                                   i_csr_valid,
   input  logic                                   i_csr_r,
   input  logic                                   i_csr_w,
   input  logic [11:0]                            i_csr_addr,
   input  logic [XLEN-1:0]                        i_csr_data,
   input  logic [XLEN-1:0]                        i_csr_wmask,
   output logic                                   i_csr_ready,
   output logic                                   i_csr_legal,
   output logic                                   i_csr_fence,
   output logic                                   o_csr_valid,
   output logic [XLEN-1:0]                        o_csr_data,
   input  logic                                   o_csr_ready
);

   localparam int          NCNT     = NUM_HPM + 2;
   localparam logic [31:0] INH_MASK = inhibit_mask(NUM_HPM);

   logic            o_valid_q, o_valid_d;
   logic [XLEN-1:0] o_data_q, o_data_d;
   logic [XLEN-1:0] mscratch_q, mscratch_d;
   logic [31:0]     minh_q, minh_d;
   logic [63:0]     cnt [NCNT];
   logic [NCNT-1:0] wr_lo, wr_hi;
   logic [63:0]     wdata64;
   logic [63:0]     slot_val;
   logic [4:0]      lo5;
   logic            exists, accept, wr_en;
   logic [XLEN-1:0] rdata, merged;

   assign lo5 = i_csr_addr[4:0];

   always_comb begin
      slot_val = '0;
      if (lo5 == 5'd0) slot_val = cnt[0];
      if (lo5 == 5'd2) slot_val = cnt[1];
      for (int k = 0; k < NUM_HPM; k++)
         if (lo5 == 5'(k + 3)) slot_val = cnt[k + 2];
   end

   // Unimplemented mhpmcounters fall through slot_val as zero
   always_comb begin
      exists = 1'b1;
      rdata  = '0;
      if (i_csr_addr inside {CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID})
         rdata = '0;
      else if (i_csr_addr == CSR_MHARTID)
         rdata = XLEN'(HART_ID);
      else if (i_csr_addr == CSR_MISA)
         rdata = XLEN'(MISA_VAL);
      else if (i_csr_addr == CSR_MSCRATCH)
         rdata = mscratch_q;
      else if (i_csr_addr == CSR_MCOUNTINHIBIT)
         rdata = XLEN'(minh_q);
      else if (i_csr_addr[11:5] == CSR_MCYCLE[11:5] && lo5 != 5'd1)
         rdata = XLEN'(slot_val);
      else if (XLEN == 32 && i_csr_addr[11:5] == CSR_MCYCLEH[11:5] && lo5 != 5'd1)
         rdata = XLEN'(slot_val[63:32]);
      else if (i_csr_addr == CSR_CYCLE || i_csr_addr == CSR_INSTRET)
         rdata = XLEN'(slot_val);
      else if (XLEN == 32 && (i_csr_addr == CSR_CYCLEH || i_csr_addr == CSR_INSTRETH))
         rdata = XLEN'(slot_val[63:32]);
      else
         exists = 1'b0;
   end

   assign i_csr_legal = exists && (i_csr_addr[11:10] != 2'b11 || !i_csr_w);
   assign i_csr_ready = !o_valid_q || o_csr_ready;
   assign i_csr_fence = 1'b0;
   assign accept      = i_csr_valid && i_csr_ready && i_csr_legal;
   assign wr_en       = accept && i_csr_w;
   assign merged      = (rdata & ~i_csr_wmask) | (i_csr_data & i_csr_wmask);

   always_comb begin
      wr_lo = '0;
      wr_hi = '0;
      for (int i = 0; i < NCNT; i++) begin
         wr_lo[i] = wr_en && (i_csr_addr == ctr_addr(i));
         wr_hi[i] = wr_en && (i_csr_addr == ((XLEN == 32) ? (ctr_addr(i) | 12'h080)
                                                          : ctr_addr(i)));
      end
   end

   if (XLEN == 32) begin : g_wd32
      assign wdata64 = {merged, merged};
   end else begin : g_wd64
      assign wdata64 = merged;
   end

   for (genvar i = 0; i < NCNT; i++) begin : g_cnt
      logic [2:0] inc;
      logic       inh;
      if (i == 0) begin : g_cy
         assign inc = 3'd1;
         assign inh = minh_q[CNT_CY];
      end else if (i == 1) begin : g_ir
         assign inc = insts_ret;
         assign inh = minh_q[CNT_IR];
      end else begin : g_hpm
         assign inc = {2'b00, hpm_event[i-2]};
         assign inh = minh_q[i+1];
      end
      mr_csr_counter u_cnt (
         .clk       (clk),
         .rst       (rst),
         .inc_i     (inc),
         .inhibit_i (inh),
         .wr_lo_i   (wr_lo[i]),
         .wr_hi_i   (wr_hi[i]),
         .wdata_i   (wdata64),
         .cnt_o     (cnt[i])
      );
   end

   always_comb begin
      o_valid_d  = o_valid_q;
      o_data_d   = o_data_q;
      mscratch_d = mscratch_q;
      minh_d     = minh_q;
      if (accept) begin
         o_valid_d = 1'b1;
         o_data_d  = rdata;
      end else if (o_csr_ready) begin
         o_valid_d = 1'b0;
         o_data_d  = '0;
      end
      if (wr_en && i_csr_addr == CSR_MSCRATCH)      mscratch_d = merged;
      if (wr_en && i_csr_addr == CSR_MCOUNTINHIBIT) minh_d     = merged[31:0] & INH_MASK;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         o_valid_q  <= 1'b0;
         o_data_q   <= '0;
         mscratch_q <= '0;
         minh_q     <= '0;
      end else begin
         o_valid_q  <= o_valid_d;
         o_data_q   <= o_data_d;
         mscratch_q <= mscratch_d;
         minh_q     <= minh_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) assert (!i_csr_valid || i_csr_r || i_csr_w);
   end

   assign o_csr_valid = o_valid_q;
   assign o_csr_data  = o_data_q;

endmodule

// File: tb/tb_mr_csr_unit.sv
// tb/tb_mr_csr_unit.sv - randomized check of mr_csr_unit against a behavioural model
module tb_mr_csr_unit;

   localparam int          NUM_HPM = 4;
   localparam int unsigned HART    = 7;
   localparam logic [63:0] MISA    = 64'h0000_0000_4000_1104;
   localparam logic [31:0] INH_M   = 32'h5 | (((32'd1 << NUM_HPM) - 32'd1) << 3);

   logic        clk, rst;
   logic [2:0]  ins;
   logic [3:0]  ev;
   logic        csr_valid, csr_r, csr_w, o_rdy;
   logic [11:0] csr_addr;
   logic [31:0] csr_data, csr_wmask;
   logic        i_csr_ready, i_csr_legal, i_csr_fence, o_csr_valid;
   logic [31:0] o_csr_data;

   int total, bad;

   logic [63:0] m_ctr [32];
   logic [31:0] m_scr, m_inh, m_data;
   logic        m_valid;

   logic [11:0] addr_tab [27] = '{12'hB00, 12'hB02, 12'hB03, 12'hB04, 12'hB05, 12'hB06,
                                  12'hB07, 12'hB1F, 12'hB80, 12'hB82, 12'hB83, 12'hB86,
                                  12'hB87, 12'hB01, 12'hB81, 12'hC00, 12'hC02, 12'hC80,
                                  12'hC82, 12'hC03, 12'hF11, 12'hF14, 12'h301, 12'h340,
                                  12'h320, 12'h300, 12'hF15};

   mr_csr_unit #(.XLEN(32), .HART_ID(HART), .MISA_VAL(MISA), .NUM_HPM(NUM_HPM)) dut (
      .clk         (clk),
      .rst         (rst),
      .insts_ret   (ins),
      .hpm_event   (ev),
      .i_csr_valid (csr_valid),
      .i_csr_r     (csr_r),
      .i_csr_w     (csr_w),
      .i_csr_addr  (csr_addr),
      .i_csr_data  (csr_data),
      .i_csr_wmask (csr_wmask),
      .i_csr_ready (i_csr_ready),
      .i_csr_legal (i_csr_legal),
      .i_csr_fence (i_csr_fence),
      .o_csr_valid (o_csr_valid),
      .o_csr_data  (o_csr_data),
      .o_csr_ready (o_rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit impl(input int n);
      return n == 0 || n == 2 || (n >= 3 && n < 3 + NUM_HPM);
   endfunction

   // {exists, value} of a CSR as the architecture defines it
   function automatic logic [32:0] m_read(input logic [11:0] a);
      int n;
      n = int'(a[4:0]);
      case (a)
         12'hF11, 12'hF12, 12'hF13: return {1'b1, 32'd0};
         12'hF14:                   return {1'b1, 32'(HART)};
         12'h301:                   return {1'b1, MISA[31:0]};
         12'h340:                   return {1'b1, m_scr};
         12'h320:                   return {1'b1, m_inh};
         12'hC00, 12'hC02:          return {1'b1, m_ctr[n][31:0]};
         12'hC80, 12'hC82:          return {1'b1, m_ctr[n][63:32]};
         default: ;
      endcase
      if (a >= 12'hB00 && a <= 12'hB1F && n != 1) return {1'b1, m_ctr[n][31:0]};
      if (a >= 12'hB80 && a <= 12'hB9F && n != 1) return {1'b1, m_ctr[n][63:32]};
      return {1'b0, 32'd0};
   endfunction

   task automatic m_reset();
      for (int k = 0; k < 32; k++) m_ctr[k] = '0;
      m_scr   = '0;
      m_inh   = '0;
      m_valid = 1'b0;
      m_data  = '0;
   endtask

   // Inputs are already applied; check combinational outputs, advance model and DUT
   task automatic tick();
      logic [32:0] rv;
      logic        lg, rdy, acc, whi;
      logic [31:0] nv;
      int          wn, n;
      #3;
      rv  = m_read(csr_addr);
      lg  = rv[32] && (csr_addr[11:10] != 2'b11 || !csr_w);
      rdy = !m_valid || o_rdy;
      acc = csr_valid && rdy && lg;
      check_eq("legal", i_csr_legal, lg);
      check_eq("ready", i_csr_ready, rdy);
      check_eq("fence", i_csr_fence, 0);
      if (rst) begin
         m_reset();
      end else begin
         nv = (rv[31:0] & ~csr_wmask) | (csr_data & csr_wmask);
         if (acc) begin
            m_valid = 1'b1;
            m_data  = rv[31:0];
         end else if (o_rdy) begin
            m_valid = 1'b0;
            m_data  = '0;
         end
         n   = int'(csr_addr[4:0]);
         wn  = -1;
         whi = 1'b0;
         if (acc && csr_w) begin
            if (csr_addr >= 12'hB00 && csr_addr <= 12'hB1F) wn = n;
            if (csr_addr >= 12'hB80 && csr_addr <= 12'hB9F) begin wn = n; whi = 1'b1; end
         end
         for (int k = 0; k < 32; k++) begin
            if (!impl(k)) continue;
            if (k == wn) begin
               if (whi) m_ctr[k][63:32] = nv;
               else     m_ctr[k][31:0]  = nv;
            end else if (!m_inh[k]) begin
               if (k == 0)      m_ctr[k] = m_ctr[k] + 64'd1;
               else if (k == 2) m_ctr[k] = m_ctr[k] + 64'(ins);
               else             m_ctr[k] = m_ctr[k] + 64'(ev[k-3]);
            end
         end
         if (acc && csr_w && csr_addr == 12'h340) m_scr = nv;
         if (acc && csr_w && csr_addr == 12'h320) m_inh = nv & INH_M;
      end
      @(posedge clk);
      #1;
      check_eq("o_valid", o_csr_valid, m_valid);
      check_eq("o_data", o_csr_data, m_data);
   endtask

   task automatic drive(input logic v, r, w, input logic [11:0] a, input logic [31:0] d, mk,
                        input logic [2:0] ir, input logic [3:0] e, input logic ordy, rs);
      csr_valid = v; csr_r = r; csr_w = w; csr_addr = a; csr_data = d; csr_wmask = mk;
      ins = ir; ev = e; o_rdy = ordy; rst = rs;
      tick();
   endtask

   task automatic idle(input int cycles);
      for (int c = 0; c < cycles; c++) drive(0, 0, 0, 12'h000, 0, 0, 0, 0, 1, 0);
   endtask

   initial begin
      int sel;
      total = 0;
      bad   = 0;
      csr_valid = 0; csr_r = 0; csr_w = 0; csr_addr = 0; csr_data = 0; csr_wmask = 0;
      ins = 0; ev = 0; o_rdy = 1; rst = 1;
      repeat (2) @(posedge clk);
      #1;
      m_reset();
      check_eq("rst_o_valid", o_csr_valid, 0);
      check_eq("rst_o_data", o_csr_data, 0);

      idle(10);
      drive(1, 1, 0, 12'hB00, 0, 0, 0, 0, 1, 0);
      idle(3);
      drive(1, 1, 0, 12'hB00, 0, 0, 0, 0, 1, 0);
      idle(1);

      drive(1, 1, 1, 12'hB00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1, 0);
      idle(1);
      drive(1, 1, 0, 12'hB80, 0, 0, 0, 0, 1, 0);
      check_eq("mcycleh_carry", o_csr_data, 32'd1);

      drive(1, 0, 1, 12'h340, 32'hA5A5_A5A5, 32'h0000_FFFF, 0, 0, 1, 0);
      drive(1, 1, 0, 12'h340, 0, 0, 0, 0, 1, 0);
      check_eq("mscratch_mask", o_csr_data, 32'h0000_A5A5);

      drive(1, 0, 1, 12'h320, 32'h5, 32'hFFFF_FFFF, 0, 0, 1, 0);
      for (int c = 0; c < 4; c++) drive(0, 0, 0, 0, 0, 0, 3'd3, 4'hF, 1, 0);
      drive(1, 1, 0, 12'hB02, 0, 0, 3'd3, 0, 1, 0);
      drive(1, 1, 0, 12'hB00, 0, 0, 3'd3, 0, 1, 0);
      drive(1, 0, 1, 12'h320, 32'h0, 32'hFFFF_FFFF, 3'd3, 0, 1, 0);
      for (int c = 0; c < 4; c++) drive(0, 0, 0, 0, 0, 0, 3'd3, 4'h5, 1, 0);
      drive(1, 1, 0, 12'hB02, 0, 0, 0, 0, 1, 0);

      drive(1, 0, 1, 12'hC00, 32'h1234, 32'hFFFF_FFFF, 0, 0, 1, 0);
      drive(1, 1, 0, 12'hC00, 0, 0, 0, 0, 1, 0);

      drive(1, 1, 0, 12'hB00, 0, 0, 0, 0, 0, 0);
      drive(1, 1, 0, 12'h340, 0, 0, 0, 0, 0, 0);
      drive(1, 1, 0, 12'h340, 0, 0, 0, 0, 0, 0);
      drive(1, 1, 0, 12'h340, 0, 0, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      drive(1, 1, 0, 12'hB02, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(2);

      for (int c = 0; c < 3000; c++) begin
         csr_valid = ($urandom_range(0, 99) < 60);
         sel       = $urandom_range(0, 2);
         csr_r     = (sel != 1);
         csr_w     = (sel != 0);
         csr_addr  = ($urandom_range(0, 9) == 0) ? 12'($urandom) : addr_tab[$urandom_range(0, 26)];
         sel       = $urandom_range(0, 9);
         csr_data  = (sel < 3) ? 32'hFFFF_FFFF : (sel == 3) ? 32'hFFFF_FFF0 : $urandom;
         csr_wmask = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom;
         ins       = 3'($urandom);
         ev        = 4'($urandom);
         o_rdy     = ($urandom_range(0, 99) < 70);
         rst       = ($urandom_range(0, 199) == 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
